// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data traffic.
// Sequences fixed-latency reads and performs read-modify-write for sub-doubleword stores.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_done,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, WR, DONE} stateT;

   stateT              state;
   logic               lastOwner;
   logic               curWe;
   logic [1:0]         curSize;
   logic [2:0]         curLane;
   logic [DATA_W-1:0]  curWdata;
   logic [CNT_W-1:0]   cnt;
   logic               grantData;
   logic               grantFetch;

   // Replace the addressed lane of oldWord; address bits below the access size are ignored.
   function automatic logic [DATA_W-1:0] mergeLane(input logic [DATA_W-1:0] oldWord,
                                                   input logic [DATA_W-1:0] newData,
                                                   input logic [1:0]        size,
                                                   input logic [2:0]        lane);
      logic [DATA_W-1:0] mask;
      logic [5:0]        shamt;
      case (size)
         2'd0:    begin mask = DATA_W'(8'hFF);         shamt = {lane, 3'b000};       end
         2'd1:    begin mask = DATA_W'(16'hFFFF);      shamt = {lane[2:1], 4'b0000}; end
         2'd2:    begin mask = DATA_W'(32'hFFFF_FFFF); shamt = {lane[2], 5'b00000};  end
         default: begin mask = '1;                     shamt = 6'd0;                 end
      endcase
      return (oldWord & ~(mask << shamt)) | ((newData & mask) << shamt);
   endfunction

   // On conflict the requester that did not win last time gets the port.
   assign grantData  = d_req & (~if_req | ~lastOwner);
   assign grantFetch = if_req & ~grantData;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         lastOwner <= 1'b0;
         owner     <= 1'b0;
         busy      <= 1'b0;
         curWe     <= 1'b0;
         curSize   <= 2'd0;
         curLane   <= 3'd0;
         curWdata  <= '0;
         cnt       <= '0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         if_done   <= 1'b0;
         d_done    <= 1'b0;
         mem_addr  <= '0;
         mem_wr    <= 1'b0;
         mem_wdata <= '0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (grantData) begin
                  owner     <= 1'b1;
                  lastOwner <= 1'b1;
                  busy      <= 1'b1;
                  curWe     <= d_we;
                  curSize   <= d_size;
                  curLane   <= d_addr[2:0];
                  curWdata  <= d_wdata;
                  mem_addr  <= {d_addr[ADDR_W-1:3], 3'b000};
                  if (d_we && (d_size == 2'd3)) begin
                     mem_wr    <= 1'b1;
                     mem_wdata <= d_wdata;
                     state     <= WR;
                  end else begin
                     cnt   <= CNT_W'(MEM_LAT);
                     state <= RD_WAIT;
                  end
               end else if (grantFetch) begin
                  owner     <= 1'b0;
                  lastOwner <= 1'b0;
                  busy      <= 1'b1;
                  curWe     <= 1'b0;
                  curLane   <= if_addr[2:0];
                  mem_addr  <= {if_addr[ADDR_W-1:3], 3'b000};
                  cnt       <= CNT_W'(MEM_LAT);
                  state     <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (cnt == CNT_W'(1)) begin
                  if (!owner) begin
                     if_rdata <= mem_rdata;
                     state    <= DONE;
                  end else if (!curWe) begin
                     d_rdata <= mem_rdata;
                     state   <= DONE;
                  end else begin
                     mem_wdata <= mergeLane(mem_rdata, curWdata, curSize, curLane);
                     mem_wr    <= 1'b1;
                     state     <= WR;
                  end
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            WR: begin
               mem_wr <= 1'b0;
               state  <= DONE;
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (owner) d_done  <= 1'b1;
               else       if_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
